// File: rtl/cpu_seq.sv
// Multi-cycle sequencer for the 8-bit four-register CPU: owns A-D, carry and PC,
// fetches from a synchronous instruction ROM and commits the combinational datapath results.
module cpu_seq #(
    parameter int PC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic            load_en,
    input  logic [1:0]      load_sel,
    input  logic [7:0]      load_data,
    output logic            imem_rd,
    output logic [PC_W-1:0] imem_addr,
    input  logic [4:0]      imem_data,
    output logic [7:0]      comb_ain,
    output logic [7:0]      comb_bin,
    output logic [7:0]      comb_cin,
    output logic [7:0]      comb_din,
    output logic            comb_carryin,
    output logic [3:0]      comb_op,
    input  logic [7:0]      comb_aout,
    input  logic [7:0]      comb_bout,
    input  logic [7:0]      comb_cout,
    input  logic [7:0]      comb_dout,
    input  logic            comb_carryout,
    output logic            busy,
    output logic            done,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      reg_a,
    output logic [7:0]      reg_b,
    output logic [7:0]      reg_c,
    output logic [7:0]      reg_d,
    output logic            carry
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DONE} state_t;

    state_t     state;
    logic [3:0] ir;
    logic       step_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            reg_a     <= '0;
            reg_b     <= '0;
            reg_c     <= '0;
            reg_d     <= '0;
            carry     <= 1'b0;
            pc        <= '0;
            ir        <= '0;
            step_mode <= 1'b0;
            imem_rd   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // start outranks step when both arrive together
                    if (start || step) begin
                        state     <= S_FETCH;
                        step_mode <= !start;
                        imem_rd   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (start || step) begin
                        pc        <= '0;
                        state     <= S_FETCH;
                        step_mode <= !start;
                        imem_rd   <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    imem_rd <= 1'b0;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    ir <= imem_data[3:0];
                    // a halt word leaves pc pointing at itself
                    if (imem_data[4]) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    reg_a <= comb_aout;
                    reg_b <= comb_bout;
                    reg_c <= comb_cout;
                    reg_d <= comb_dout;
                    carry <= comb_carryout;
                    pc    <= pc + PC_W'(1);
                    if (step_mode) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= S_FETCH;
                        imem_rd <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // host writes only land while the sequencer is parked
            if (load_en && (state == S_IDLE || state == S_DONE)) begin
                case (load_sel)
                    2'd0: reg_a <= load_data;
                    2'd1: reg_b <= load_data;
                    2'd2: reg_c <= load_data;
                    2'd3: reg_d <= load_data;
                endcase
            end
        end
    end

    assign imem_addr    = pc;
    assign comb_ain     = reg_a;
    assign comb_bin     = reg_b;
    assign comb_cin     = reg_c;
    assign comb_din     = reg_d;
    assign comb_carryin = carry;
    assign comb_op      = (state == S_EXEC) ? ir : 4'h0;

endmodule

// File: doc/cpu_seq.md
Name: cpu_seq

Overview:
Multi-cycle sequencer for the 8-bit, four-register combinational CPU datapath.
- Owns the architectural state: registers A–D, carry and PC.
- Fetches 5-bit instruction words from an external synchronous instruction ROM.
- Presents the current state plus the 4-bit op to the combinational datapath and commits the datapath's outputs.
- Supports host preload of registers, free-run, single-step and halt.

Parameters:
PC_W, 6, width of program counter / instruction address (program space 2^PC_W words)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse: run from current PC (from IDLE) or from PC=0 (from DONE)
step  in  1  pulse: execute exactly one instruction, then return to IDLE
load_en  in  1  host register write strobe
load_sel  in  2  0=A 1=B 2=C 3=D
load_data  in  8  host write data
imem_rd  out  1  instruction read strobe
imem_addr  out  PC_W  instruction address
imem_data  in  5  [4]=halt flag, [3:0]=op; valid the cycle after imem_rd
comb_ain, comb_bin, comb_cin, comb_din  out  8 each  current A..D to datapath
comb_carryin  out  1  current carry to datapath
comb_op  out  4  op of the executing instruction
comb_aout, comb_bout, comb_cout, comb_dout  in  8 each  datapath results
comb_carryout  in  1  datapath carry result
busy  out  1  high in FETCH/DECODE/EXEC
done  out  1  high in DONE
pc  out  PC_W  current PC
reg_a, reg_b, reg_c, reg_d  out  8 each  architectural registers
carry  out  1  architectural carry

Behaviour:
- Reset: state=IDLE; A=B=C=D=0; carry=0; pc=0; ir=0; step_mode=0; imem_rd=0; busy=0; done=0. Reset mid-instruction aborts with no commit.
- States: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE:
  - start → FETCH with step_mode=0.
  - step (without start) → FETCH with step_mode=1.
  - start and step together: start wins.
- DONE:
  - start → pc<=0, FETCH, step_mode=0.
  - step → pc<=0, FETCH, step_mode=1.
  - otherwise hold; done=1.
- FETCH: imem_rd=1, imem_addr=pc; next DECODE.
- DECODE: ir<=imem_data.
  - imem_data[4]=1 → DONE; no execute; pc unchanged (points at halt word).
  - otherwise → EXEC.
- EXEC:
  - comb_op=ir[3:0]; comb_* ins = current regs/carry.
  - At end of cycle: A<=comb_aout, B<=comb_bout, C<=comb_cout, D<=comb_dout, carry<=comb_carryout, pc<=pc+1.
  - Next state is IDLE if step_mode, else FETCH.
- comb_op is 0 outside EXEC. comb_* register outputs always reflect the current registers.
- Timing:
  - 3 cycles per instruction.
  - With start sampled at edge t, the first commit happens at edge t+3.
  - Halt is detected at edge t+2 after the halt word's FETCH.
- PC arithmetic: modulo 2^PC_W. Wrap from all-ones to 0 is silent; execution continues.
- load_en:
  - Honoured only in IDLE or DONE: writes register load_sel at the edge.
  - Ignored while busy.
  - load_en with start in the same IDLE cycle: the load takes effect and the run starts; the first EXEC sees the loaded value.
- start/step while busy: ignored, not queued.
- imem_rd asserted only in FETCH; imem_data sampled only in DECODE.

Test Plan:
- Reset then idle 5 cycles → all regs 0, pc=0, busy=0, done=0, imem_rd never high.
- Preload A=0x5A; ROM[0]=0x0E, ROM[1]=0x0F, ROM[2]=0x10; stub comb with cout=(op==E)?ain:cin, dout=(op==F)?ain:din, others passthrough; start → C=0x5A, D=0x5A, done=1 exactly 8 cycles after start, pc=2.
- Stub returns aout=0x33, carryout=1 for any op; ROM[0]=0x03, ROM[1]=0x10; step pulse → after 3 cycles A=0x33, carry=1, pc=1, state IDLE; start → DONE at pc=1 with no second commit.
- Pulse start, load_en (sel=2, data=0xFF) and step while busy → ignored; C unchanged, run completes normally; then start in DONE → pc restarts at 0.
- PC_W=2, ROM all 0x00 (no halt) → pc sequence 0,1,2,3,0; still busy; imem_addr wraps.
- Assert rst during EXEC with stub outputs 0xAA → regs stay 0, state IDLE next cycle.
